// File: rtl/wide_add_pkg.sv
// Shared definitions for the wide-operand adder sequencer: chunk width, FSM state type
// and the per-chunk carry/sign-carry helper.
package wide_add_pkg;

  localparam int CHUNK = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns {carry out of bit 15, carry into bit 15}, recovered from the MSBs of a chunk add.
  function automatic logic [1:0] chunk_carry(input logic a15, input logic b15, input logic s15);
    logic c15;
    c15 = s15 ^ a15 ^ b15;
    return {(a15 & b15) | ((a15 ^ b15) & c15), c15};
  endfunction

endpackage

// File: rtl/wide_add_sequencer_adder.sv
// 16-bit Kogge-Stone prefix adder with carry-in; the datapath shared by every chunk.
module wide_add_sequencer_adder
  import wide_add_pkg::*;
(
  input  logic             cin,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK-1:0] g_lvl [0:4];
  logic [CHUNK-1:0] p_lvl [0:3];

  // Carry-in folds into bit 0's generate so the prefix tree yields true carries.
  assign p_lvl[0] = a ^ b;
  assign g_lvl[0] = (a & b) | {{(CHUNK-1){1'b0}}, p_lvl[0][0] & cin};

  for (genvar lvl = 0; lvl < 4; lvl++) begin : g_level
    localparam int DIST = 1 << lvl;
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      if (i >= DIST) begin : g_merge
        assign g_lvl[lvl+1][i] = g_lvl[lvl][i] | (p_lvl[lvl][i] & g_lvl[lvl][i-DIST]);
      end else begin : g_pass
        assign g_lvl[lvl+1][i] = g_lvl[lvl][i];
      end
      if (lvl < 3) begin : g_prop
        if (i >= DIST) begin : g_pmerge
          assign p_lvl[lvl+1][i] = p_lvl[lvl][i] & p_lvl[lvl][i-DIST];
        end else begin : g_ppass
          assign p_lvl[lvl+1][i] = p_lvl[lvl][i];
        end
      end
    end
  end

  assign s    = p_lvl[0] ^ {g_lvl[4][CHUNK-2:0], cin};
  assign cout = g_lvl[4][CHUNK-1];

endmodule

// File: rtl/wide_add_sequencer.sv
// Adds (or, with WIDE_ADD_SUB_EN defined, subtracts) WIDTH-bit operands one 16-bit chunk
// per cycle through a single prefix adder, LSB chunk first, with valid/ready on both sides.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             eff_sub_s;
  logic [CHUNK-1:0] chunk_a_s;
  logic [CHUNK-1:0] chunk_b_s;
  logic [CHUNK-1:0] chunk_s_s;
  logic [1:0]       chunk_c_s;
  logic             chunk_cout_unused_s;

`ifdef WIDE_ADD_SUB_EN
  assign eff_sub_s = sub;
`else
  logic sub_unused_s;
  assign sub_unused_s = sub;
  assign eff_sub_s    = 1'b0;
`endif

  assign chunk_a_s = a_q[idx_q*CHUNK +: CHUNK];
  assign chunk_b_s = b_q[idx_q*CHUNK +: CHUNK];

  wide_add_sequencer_adder u_adder (
    .cin  (carry_q),
    .a    (chunk_a_s),
    .b    (chunk_b_s),
    .s    (chunk_s_s),
    .cout (chunk_cout_unused_s)
  );

  // The adder's own carry-out is not trusted; the chunk carry is re-derived from the MSBs.
  assign chunk_c_s = chunk_carry(chunk_a_s[CHUNK-1], chunk_b_s[CHUNK-1], chunk_s_s[CHUNK-1]);

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = eff_sub_s ? ~op_b : op_b;
          carry_d = eff_sub_s;
          idx_d   = IDXW'(0);
          sum_d   = {WIDTH{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[idx_q*CHUNK +: CHUNK] = chunk_s_s;
        carry_d = chunk_c_s[1];
        if (idx_q == LAST_IDX) begin
          cout_d  = chunk_c_s[1];
          ovf_d   = chunk_c_s[1] ^ chunk_c_s[0];
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= IDXW'(0);
      carry_q <= 1'b0;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
